// File: rtl/complex_mult_pipe.sv
// ============================================================================
// Module      : complex_mult_pipe
// Description : Three-stage signed fixed-point complex multiplier with
//               conjugation, rounding, saturation and complex MAC mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_mult_pipe #(
    parameter int COMPLEX_BIT = 24,
    parameter int FP_BIT      = 22,
    parameter int ACC_GUARD   = 4,
    parameter int ROUND       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COMPLEX_BIT-1:0] in_r1,
    input  logic [COMPLEX_BIT-1:0] in_i1,
    input  logic [COMPLEX_BIT-1:0] in_r2,
    input  logic [COMPLEX_BIT-1:0] in_i2,
    input  logic                   in_conj,
    input  logic                   in_acc,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COMPLEX_BIT-1:0] out_r,
    output logic [COMPLEX_BIT-1:0] out_i,
    output logic                   out_sat
);

    localparam int c_w = COMPLEX_BIT;
    localparam int c_p = 2 * COMPLEX_BIT + 1;
    localparam int c_a = 2 * COMPLEX_BIT + ACC_GUARD;

    localparam logic signed [c_a:0] c_one = {{c_a{1'b0}}, 1'b1};
    localparam logic signed [c_a:0] c_rnd = (ROUND != 0) ? (c_one <<< (FP_BIT - 1)) : '0;
    localparam logic signed [c_a:0] c_max = {{(c_a + 2 - c_w){1'b0}}, {(c_w - 1){1'b1}}};
    localparam logic signed [c_a:0] c_min = {{(c_a + 2 - c_w){1'b1}}, {(c_w - 1){1'b0}}};

    // Returns {saturated, value}; input is one bit wider than the accumulator
    // so the rounding add can never wrap.
    function automatic logic [c_w:0] f_scale(input logic signed [c_a:0] v);
        logic signed [c_a:0] t;
        logic signed [c_a:0] s;
        t = v + c_rnd;
        s = t >>> FP_BIT;
        if (s > c_max) begin
            return {1'b1, c_max[c_w-1:0]};
        end else if (s < c_min) begin
            return {1'b1, c_min[c_w-1:0]};
        end else begin
            return {1'b0, s[c_w-1:0]};
        end
    endfunction

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------------------------------------------------------- S1
    logic signed [c_w:0]   w_i2_ext;
    logic signed [c_w:0]   w_i2_op;
    logic                  r_s1_valid;
    logic                  r_s1_acc;
    logic                  r_s1_last;
    logic signed [c_w-1:0] r_s1_r1;
    logic signed [c_w-1:0] r_s1_i1;
    logic signed [c_w-1:0] r_s1_r2;
    logic signed [c_w:0]   r_s1_i2;

    // Extra bit keeps -(min) representable.
    assign w_i2_ext = {in_i2[c_w-1], in_i2};
    assign w_i2_op  = in_conj ? -w_i2_ext : w_i2_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_acc   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_r1    <= '0;
            r_s1_i1    <= '0;
            r_s1_r2    <= '0;
            r_s1_i2    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_acc   <= in_acc;
            r_s1_last  <= in_acc & in_last;
            r_s1_r1    <= in_r1;
            r_s1_i1    <= in_i1;
            r_s1_r2    <= in_r2;
            r_s1_i2    <= w_i2_op;
        end
    end

    // ---------------------------------------------------------------- S2
    logic signed [c_p-1:0] w_r1x;
    logic signed [c_p-1:0] w_i1x;
    logic signed [c_p-1:0] w_r2x;
    logic signed [c_p-1:0] w_i2x;
    logic                  r_s2_valid;
    logic                  r_s2_acc;
    logic                  r_s2_last;
    logic signed [c_p-1:0] r_s2_rr;
    logic signed [c_p-1:0] r_s2_ii;
    logic signed [c_p-1:0] r_s2_ri;
    logic signed [c_p-1:0] r_s2_ir;

    assign w_r1x = {{(c_p - c_w){r_s1_r1[c_w-1]}}, r_s1_r1};
    assign w_i1x = {{(c_p - c_w){r_s1_i1[c_w-1]}}, r_s1_i1};
    assign w_r2x = {{(c_p - c_w){r_s1_r2[c_w-1]}}, r_s1_r2};
    assign w_i2x = {{(c_p - c_w - 1){r_s1_i2[c_w]}}, r_s1_i2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_acc   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_rr    <= '0;
            r_s2_ii    <= '0;
            r_s2_ri    <= '0;
            r_s2_ir    <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_acc   <= r_s1_acc;
            r_s2_last  <= r_s1_last;
            r_s2_rr    <= w_r1x * w_r2x;
            r_s2_ii    <= w_i1x * w_i2x;
            r_s2_ri    <= w_r1x * w_i2x;
            r_s2_ir    <= w_i1x * w_r2x;
        end
    end

    // ---------------------------------------------------------------- S3
    logic signed [c_p-1:0] w_re;
    logic signed [c_p-1:0] w_im;
    logic signed [c_a-1:0] w_re_a;
    logic signed [c_a-1:0] w_im_a;
    logic signed [c_a-1:0] w_sum_r;
    logic signed [c_a-1:0] w_sum_i;
    logic signed [c_a-1:0] w_pre_r;
    logic signed [c_a-1:0] w_pre_i;
    logic [c_w:0]          w_sc_r;
    logic [c_w:0]          w_sc_i;
    logic signed [c_a-1:0] r_acc_r;
    logic signed [c_a-1:0] r_acc_i;

    assign w_re    = r_s2_rr - r_s2_ii;
    assign w_im    = r_s2_ri + r_s2_ir;
    assign w_re_a  = {{(c_a - c_p){w_re[c_p-1]}}, w_re};
    assign w_im_a  = {{(c_a - c_p){w_im[c_p-1]}}, w_im};
    // Accumulator sums wrap at c_a bits by design.
    assign w_sum_r = r_acc_r + w_re_a;
    assign w_sum_i = r_acc_i + w_im_a;
    assign w_pre_r = r_s2_last ? w_sum_r : w_re_a;
    assign w_pre_i = r_s2_last ? w_sum_i : w_im_a;
    assign w_sc_r  = f_scale({w_pre_r[c_a-1], w_pre_r});
    assign w_sc_i  = f_scale({w_pre_i[c_a-1], w_pre_i});

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sat   <= 1'b0;
            r_acc_r   <= '0;
            r_acc_i   <= '0;
        end else if (w_adv) begin
            out_valid <= 1'b0;
            if (r_s2_valid) begin
                if (r_s2_acc && !r_s2_last) begin
                    r_acc_r <= w_sum_r;
                    r_acc_i <= w_sum_i;
                end else begin
                    out_valid <= 1'b1;
                    out_r     <= w_sc_r[c_w-1:0];
                    out_i     <= w_sc_i[c_w-1:0];
                    out_sat   <= w_sc_r[c_w] | w_sc_i[c_w];
                    if (r_s2_last) begin
                        r_acc_r <= '0;
                        r_acc_i <= '0;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_complex_mult_pipe.sv
// ============================================================================
// Module      : tb_complex_mult_pipe
// Description : Self-checking bench for complex_mult_pipe (ROUND=1 and ROUND=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complex_mult_pipe;

    localparam int W  = 24;
    localparam int FP = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          rdy1;
    logic [W-1:0]  in_r1, in_i1, in_r2, in_i2;
    logic          in_conj, in_acc, in_last;
    logic          out_ready;
    logic          o0_valid, o1_valid;
    logic [W-1:0]  o0_r, o0_i, o1_r, o1_i;
    logic          o0_sat, o1_sat;

    always #5 clk = ~clk;

    complex_mult_pipe #(.COMPLEX_BIT(W), .FP_BIT(FP), .ACC_GUARD(4), .ROUND(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r1(in_r1), .in_i1(in_i1), .in_r2(in_r2), .in_i2(in_i2),
        .in_conj(in_conj), .in_acc(in_acc), .in_last(in_last),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_r(o0_r), .out_i(o0_i), .out_sat(o0_sat)
    );

    complex_mult_pipe #(.COMPLEX_BIT(W), .FP_BIT(FP), .ACC_GUARD(4), .ROUND(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_r1(in_r1), .in_i1(in_i1), .in_r2(in_r2), .in_i2(in_i2),
        .in_conj(in_conj), .in_acc(in_acc), .in_last(in_last),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_r(o1_r), .out_i(o1_i), .out_sat(o1_sat)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          n_out  = 0;
    int          chain  = 0;
    bit          lat_chk = 1'b0;
    bit          accepted;
    longint      macr = 0;
    longint      maci = 0;
    logic [48:0] q0[$];
    logic [48:0] q1[$];
    int          qc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference scaling: add half LSB if rounding, floor-divide by 2^FP, clamp.
    function automatic logic [48:0] scale2(input longint vr, input longint vi, input bit rnd);
        longint hi, lo, a, b;
        logic   sr, si;
        logic [63:0] ua, ub;
        hi = 64'sd8388607;
        lo = -64'sd8388608;
        a  = (vr + (rnd ? 64'sd2097152 : 64'sd0)) >>> FP;
        b  = (vi + (rnd ? 64'sd2097152 : 64'sd0)) >>> FP;
        sr = (a > hi) || (a < lo);
        si = (b > hi) || (b < lo);
        if (a > hi) a = hi;
        if (a < lo) a = lo;
        if (b > hi) b = hi;
        if (b < lo) b = lo;
        ua = a;
        ub = b;
        return {sr | si, ua[23:0], ub[23:0]};
    endfunction

    task automatic model();
        longint a, b, c, d, re, im;
        a  = sx(in_r1);
        b  = sx(in_i1);
        c  = sx(in_r2);
        d  = in_conj ? -sx(in_i2) : sx(in_i2);
        re = a * c - b * d;
        im = a * d + b * c;
        if (in_acc && !in_last) begin
            macr += re;
            maci += im;
            chain++;
        end else begin
            if (in_acc) begin
                re += macr;
                im += maci;
                macr  = 0;
                maci  = 0;
                chain = 0;
            end
            q0.push_back(scale2(re, im, 1'b1));
            q1.push_back(scale2(re, im, 1'b0));
            qc.push_back(cyc);
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [48:0] e;
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        if (rst) begin
            q0.delete();
            q1.delete();
            qc.delete();
            macr  = 0;
            maci  = 0;
            chain = 0;
        end else begin
            if (o0_valid) begin
                if (q0.size() == 0) begin
                    check("spurious_out0", {63'd0, o0_valid}, 64'd0);
                end else begin
                    e = q0[0];
                    check("out_r_rnd", {40'd0, o0_r}, {40'd0, e[47:24]});
                    check("out_i_rnd", {40'd0, o0_i}, {40'd0, e[23:0]});
                    check("out_sat_rnd", {63'd0, o0_sat}, {63'd0, e[48]});
                    if (out_ready) begin
                        if (lat_chk) check("latency", 64'(cyc - qc[0]), 64'd3);
                        void'(q0.pop_front());
                        void'(qc.pop_front());
                        n_out++;
                    end
                end
            end
            if (o1_valid) begin
                if (q1.size() == 0) begin
                    check("spurious_out1", {63'd0, o1_valid}, 64'd0);
                end else begin
                    e = q1[0];
                    check("out_r_trunc", {40'd0, o1_r}, {40'd0, e[47:24]});
                    check("out_i_trunc", {40'd0, o1_i}, {40'd0, e[23:0]});
                    check("out_sat_trunc", {63'd0, o1_sat}, {63'd0, e[48]});
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                n_acc++;
                model();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] r1, input logic [W-1:0] i1,
                         input logic [W-1:0] r2, input logic [W-1:0] i2,
                         input bit conj, input bit acc, input bit last);
        int k;
        in_valid = 1'b1;
        in_r1 = r1; in_i1 = i1; in_r2 = r2; in_i2 = i2;
        in_conj = conj; in_acc = acc; in_last = last;
        k = 0;
        accepted = 1'b0;
        while (!accepted && k < 100) begin
            tick();
            k++;
        end
        check("accept_timeout", {63'd0, accepted}, 64'd1);
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
        repeat (5) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k, bo;
        logic [W-1:0] corners[6];
        corners[0] = 24'h800000; corners[1] = 24'h7FFFFF; corners[2] = 24'h400000;
        corners[3] = 24'hC00000; corners[4] = 24'h000000; corners[5] = 24'h000001;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r1 = '0; in_i1 = '0; in_r2 = '0; in_i2 = '0;
        in_conj = 1'b0; in_acc = 1'b0; in_last = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", {63'd0, o0_valid}, 64'd0);
        check("rst_out_r", {40'd0, o0_r}, 64'd0);
        check("rst_out_i", {40'd0, o0_i}, 64'd0);
        check("rst_out_sat", {63'd0, o0_sat}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_in_ready1", {63'd0, rdy1}, 64'd1);

        // Directed cases with full-throughput latency checking.
        lat_chk = 1'b1;
        drive(24'h200000, 24'h200000, 24'h200000, 24'hE00000, 0, 0, 0);
        drive(24'h200000, 24'h200000, 24'h200000, 24'h200000, 1, 0, 0);
        drive(24'h000001, 24'h000000, 24'h200000, 24'h000000, 0, 0, 0);
        drive(24'h800000, 24'h000000, 24'h800000, 24'h000000, 0, 0, 0);
        drive(24'h800000, 24'h000000, 24'h7FFFFF, 24'h000000, 0, 0, 0);
        drive(24'h000000, 24'h400000, 24'h000000, 24'h800000, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(24'h200000, 24'h000000, 24'h200000, 24'h000000, 0, 1, i == 3);
        drive(24'h400000, 24'h000000, 24'h400000, 24'h000000, 0, 0, 1);
        drain();
        check("directed_count", 64'(n_out), 64'd8);

        // Backpressure: five beats offered with the output blocked.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        base = n_acc;
        bo = n_out;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 5);
            in_r1 = 24'(24'h100000 * (k + 1)); in_i1 = 24'h000000;
            in_r2 = 24'h400000; in_i2 = 24'(24'h080000 * k);
            in_conj = 1'b0; in_acc = 1'b0; in_last = 1'b0;
            tick();
            if (accepted) k++;
        end
        check("bp_accepted", 64'(n_acc - base), 64'd3);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, o0_valid}, 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && k < 5; c++) begin
            in_valid = 1'b1;
            in_r1 = 24'(24'h100000 * (k + 1)); in_i1 = 24'h000000;
            in_r2 = 24'h400000; in_i2 = 24'(24'h080000 * k);
            tick();
            if (accepted) k++;
        end
        drain();
        check("bp_out_count", 64'(n_out - bo), 64'd5);

        // Reset in the middle of an accumulation chain.
        drive(24'h200000, 24'h000000, 24'h200000, 24'h000000, 0, 1, 0);
        drive(24'h200000, 24'h000000, 24'h200000, 24'h000000, 0, 1, 0);
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bo = n_out;
        drive(24'h200000, 24'h000000, 24'h200000, 24'h000000, 0, 1, 1);
        drain();
        check("mac_reset_count", 64'(n_out - bo), 64'd1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
            in_r1 = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 24'($urandom());
            in_i1 = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 24'($urandom());
            in_r2 = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 24'($urandom());
            in_i2 = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 24'($urandom());
            in_conj = $urandom_range(0, 1) == 1;
            in_acc  = $urandom_range(0, 2) == 0;
            in_last = in_acc ? (chain >= 7 || $urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 1'b0;
        in_acc = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
